// File: rtl/rrf_pkg.sv
// Shared types and constants for the retirement register file write path.
package rrf_pkg;
  localparam int RRF_NPORT = 10;
  localparam int RRF_AW    = 6;

  typedef logic [RRF_NPORT-1:0][RRF_AW-1:0] rrf_addr_vec_t;

  // Control half of a retire group; its data travels in a parallel array since its width is a parameter.
  typedef struct packed {
    logic [RRF_NPORT-1:0] wen;
    rrf_addr_vec_t        addr;
    logic                 thread;
    logic                 dead;
  } rrf_wgrp_t;

  function automatic int rrf_chunks(input int addr_count);
    return (addr_count + RRF_NPORT - 1) / RRF_NPORT;
  endfunction
endpackage

// File: rtl/rrf_wconf_resolve.sv
// Combinational per-group filter: youngest slot wins on address collisions, out-of-range slots dropped.
module rrf_wconf_resolve
  import rrf_pkg::*;
#(
  parameter int ADDR_COUNT = 32
) (
  input  logic [RRF_NPORT-1:0] wen,
  input  rrf_addr_vec_t        addr,
  output logic [RRF_NPORT-1:0] wen_out,
  output logic                 range_err
);
  localparam logic [RRF_AW:0] ADDR_LIM = (RRF_AW + 1)'(ADDR_COUNT);

  logic [RRF_NPORT-1:0] shadowed;
  logic [RRF_NPORT-1:0] out_of_range;

  always_comb begin
    shadowed     = '0;
    out_of_range = '0;
    for (int i = 0; i < RRF_NPORT; i++) begin
      for (int j = i + 1; j < RRF_NPORT; j++) begin
        shadowed[i] = shadowed[i] | (wen[j] & (addr[j] == addr[i]));
      end
      out_of_range[i] = ({1'b0, addr[i]} >= ADDR_LIM);
    end
    wen_out   = wen & ~shadowed & ~out_of_range;
    range_err = |(wen & out_of_range);
  end
endmodule

// File: rtl/rrf_wr_sched.sv
// Retire-group write scheduler: zero-init sweep after reset, then a group FIFO drained one group per cycle
// into the registered rrf write port, with collision/range filtering and per-thread flush.
module rrf_wr_sched
  import rrf_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int EXTRA      = 0,
  parameter int DEPTH      = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_vld,
  output logic                                   in_rdy,
  input  logic [RRF_NPORT-1:0]                   in_wen,
  input  logic [RRF_NPORT-1:0][RRF_AW-1:0]       in_addr,
  input  logic [RRF_NPORT-1:0][DATA_WIDTH-1:0]   in_data,
  input  logic                                   in_thread,
  input  logic                                   flush,
  input  logic                                   flush_thread,
  output logic [RRF_NPORT-1:0]                   write0_wen,
  output logic [RRF_NPORT-1:0][RRF_AW-1:0]       write0_addr,
  output logic [RRF_NPORT-1:0][DATA_WIDTH-1:0]   write0_data,
  output logic                                   write_thread,
  output logic                                   init_done,
  output logic                                   err_addr
);
  localparam int ADDR_COUNT = 32 + 16 * EXTRA;
  localparam int NCHUNK     = rrf_chunks(ADDR_COUNT);
  localparam int PW         = $clog2(DEPTH);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                                 state, state_nxt;
  logic [3:0]                             chunk;
  logic                                   init_thread;
  logic                                   last_chunk;
  logic [7:0]                             chunk_base;
  logic [RRF_NPORT-1:0]                   init_wen;
  rrf_addr_vec_t                          init_addr;

  rrf_wgrp_t                              grp_mem  [DEPTH];
  logic [RRF_NPORT-1:0][DATA_WIDTH-1:0]   data_mem [DEPTH];
  logic [PW-1:0]                          wptr, rptr;
  logic [PW:0]                            count;

  rrf_wgrp_t                              head;
  logic                                   push, pop, flush_run, head_dead;
  logic [RRF_NPORT-1:0]                   head_wen;
  logic                                   head_rerr;

  assign in_rdy     = init_done & (count < (PW + 1)'(DEPTH));
  assign push       = in_vld & in_rdy;
  assign pop        = (state == ST_RUN) & (count != '0);
  assign flush_run  = flush & (state == ST_RUN);
  assign head       = grp_mem[rptr];
  // A flush on the pop edge still catches the head: it has not reached the output registers yet.
  assign head_dead  = head.dead | (flush_run & (head.thread == flush_thread));
  assign last_chunk = (chunk == 4'(NCHUNK - 1)) & init_thread;

  rrf_wconf_resolve #(.ADDR_COUNT(ADDR_COUNT)) u_resolve (
    .wen       (head.wen),
    .addr      (head.addr),
    .wen_out   (head_wen),
    .range_err (head_rerr)
  );

  always_comb begin
    chunk_base = 8'(chunk) * 8'd10;
    for (int i = 0; i < RRF_NPORT; i++) begin
      init_addr[i] = 6'(chunk_base + 8'(i));
      init_wen[i]  = (chunk_base + 8'(i)) < 8'(ADDR_COUNT);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT: state_nxt = last_chunk ? ST_RUN : ST_INIT;
      ST_RUN:  state_nxt = ST_RUN;
      default: state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      chunk        <= 4'd0;
      init_thread  <= 1'b0;
      init_done    <= 1'b0;
      err_addr     <= 1'b0;
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      write0_wen   <= '0;
      write0_addr  <= '0;
      write0_data  <= '0;
      write_thread <= 1'b0;
    end else begin
      init_done <= (state == ST_RUN);
      if (state == ST_INIT) begin
        write0_wen   <= init_wen;
        write0_addr  <= init_addr;
        write0_data  <= '0;
        write_thread <= init_thread;
        if (chunk == 4'(NCHUNK - 1)) begin
          chunk       <= 4'd0;
          init_thread <= 1'b1;
        end else begin
          chunk <= chunk + 4'd1;
        end
      end else if (pop) begin
        write0_wen   <= head_dead ? '0 : head_wen;
        write0_addr  <= head.addr;
        write0_data  <= data_mem[rptr];
        write_thread <= head.thread;
        if (!head_dead && head_rerr) err_addr <= 1'b1;
      end else begin
        write0_wen <= '0;
      end
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW + 1)'(1);
        2'b01:   count <= count - (PW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; only entries inside the count window are ever read.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (flush_run && grp_mem[i].thread == flush_thread) grp_mem[i].dead <= 1'b1;
    end
    if (push) begin
      grp_mem[wptr]  <= '{wen: in_wen, addr: in_addr, thread: in_thread,
                          dead: flush_run & (in_thread == flush_thread)};
      data_mem[wptr] <= in_data;
    end
  end
endmodule

// File: tb/tb_rrf_wr_sched.sv
// Directed self-checking bench for rrf_wr_sched: init sweep, table-driven group stream, flush, range, reset.
module tb_rrf_wr_sched;
  localparam int DW = 16;
  localparam int NV = 6;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  in_vld = 1'b0;
  logic [9:0]            in_wen = '0;
  logic [9:0][5:0]       in_addr = '0;
  logic [9:0][DW-1:0]    in_data = '0;
  logic                  in_thread = 1'b0;
  logic                  flush = 1'b0;
  logic                  flush_thread = 1'b0;

  logic                  in_rdy, write_thread, init_done, err_addr;
  logic [9:0]            write0_wen;
  logic [9:0][5:0]       write0_addr;
  logic [9:0][DW-1:0]    write0_data;
  logic                  in_rdy1, write_thread1, init_done1, err_addr1;
  logic [9:0]            write0_wen1;
  logic [9:0][5:0]       write0_addr1;
  logic [9:0][DW-1:0]    write0_data1;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rrf_wr_sched #(.DATA_WIDTH(DW), .EXTRA(0), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_wen(in_wen), .in_addr(in_addr),
    .in_data(in_data), .in_thread(in_thread), .flush(flush), .flush_thread(flush_thread),
    .write0_wen(write0_wen), .write0_addr(write0_addr), .write0_data(write0_data),
    .write_thread(write_thread), .init_done(init_done), .err_addr(err_addr));

  rrf_wr_sched #(.DATA_WIDTH(DW), .EXTRA(1), .DEPTH(4)) dut1 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in_rdy(in_rdy1), .in_wen(in_wen), .in_addr(in_addr),
    .in_data(in_data), .in_thread(in_thread), .flush(flush), .flush_thread(flush_thread),
    .write0_wen(write0_wen1), .write0_addr(write0_addr1), .write0_data(write0_data1),
    .write_thread(write_thread1), .init_done(init_done1), .err_addr(err_addr1));

  typedef struct {
    logic [9:0]         wen;
    logic [9:0][5:0]    addr;
    logic [9:0][DW-1:0] data;
    logic               thr;
    logic [9:0]         exp_wen;
  } vec_t;

  vec_t tbl [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [9:0] wen, input logic [9:0][5:0] addr,
                       input logic [9:0][DW-1:0] data, input logic thr);
    in_vld = 1'b1; in_wen = wen; in_addr = addr; in_data = data; in_thread = thr;
  endtask

  task automatic check_vec(input int k);
    chk($sformatf("vec%0d_wen", k), 160'(write0_wen), 160'(tbl[k].exp_wen));
    chk($sformatf("vec%0d_thread", k), 160'(write_thread), 160'(tbl[k].thr));
    if (tbl[k].exp_wen != 10'h000) begin
      chk($sformatf("vec%0d_addr", k), 160'(write0_addr), 160'(tbl[k].addr));
      chk($sformatf("vec%0d_data", k), 160'(write0_data), 160'(tbl[k].data));
    end
  endtask

  // Expects the eight init cycles to follow; inputs are left as the caller set them.
  task automatic check_init_sweep(input string tag);
    logic [9:0] exp_w;
    for (int n = 0; n < 8; n++) begin
      tick();
      exp_w = ((n % 4) == 3) ? 10'h003 : 10'h3FF;
      chk($sformatf("%s_init%0d_wen", tag, n + 1), 160'(write0_wen), 160'(exp_w));
      chk($sformatf("%s_init%0d_thread", tag, n + 1), 160'(write_thread), 160'(n / 4));
      chk($sformatf("%s_init%0d_addr0", tag, n + 1), 160'(write0_addr[0]), 160'((n % 4) * 10));
      chk($sformatf("%s_init%0d_data", tag, n + 1), 160'(write0_data), 160'(0));
      chk($sformatf("%s_init%0d_done", tag, n + 1), 160'(init_done), 160'(0));
      chk($sformatf("%s_init%0d_rdy", tag, n + 1), 160'(in_rdy), 160'(0));
    end
  endtask

  initial begin
    logic [9:0][5:0]    a;
    logic [9:0][DW-1:0] d;
    int                 waited;

    // Stimulus table
    for (int k = 0; k < NV; k++) begin
      for (int i = 0; i < 10; i++) tbl[k].data[i] = DW'(k * 256 + i + 1);
      tbl[k].addr = '0;
    end
    tbl[0].wen = 10'h081; tbl[0].addr[0] = 6'd5; tbl[0].addr[7] = 6'd5;
    tbl[0].data[0] = 16'h000A; tbl[0].data[7] = 16'h000B; tbl[0].thr = 1'b0; tbl[0].exp_wen = 10'h080;
    for (int i = 0; i < 10; i++) tbl[1].addr[i] = 6'(20 + i);
    tbl[1].wen = 10'h3FF; tbl[1].thr = 1'b1; tbl[1].exp_wen = 10'h3FF;
    for (int i = 0; i < 10; i++) tbl[2].addr[i] = 6'd3;
    tbl[2].wen = 10'h3FF; tbl[2].thr = 1'b0; tbl[2].exp_wen = 10'h200;
    tbl[3].addr[0] = 6'd31; tbl[3].addr[1] = 6'd0; tbl[3].addr[2] = 6'd31; tbl[3].addr[3] = 6'd1;
    tbl[3].wen = 10'h00F; tbl[3].thr = 1'b1; tbl[3].exp_wen = 10'h00E;
    tbl[4].wen = 10'h000; tbl[4].thr = 1'b0; tbl[4].exp_wen = 10'h000;
    tbl[5].addr[8] = 6'd10; tbl[5].addr[9] = 6'd10;
    tbl[5].wen = 10'h300; tbl[5].thr = 1'b1; tbl[5].exp_wen = 10'h200;

    // Reset state
    tick(); tick();
    chk("rst_wen", 160'(write0_wen), 160'(0));
    chk("rst_rdy", 160'(in_rdy), 160'(0));
    chk("rst_done", 160'(init_done), 160'(0));
    chk("rst_err", 160'(err_addr), 160'(0));
    chk("rst_thread", 160'(write_thread), 160'(0));
    rst = 1'b0;

    check_init_sweep("boot");
    tick();
    chk("boot_done9", 160'(init_done), 160'(1));
    chk("boot_wen9", 160'(write0_wen), 160'(0));
    chk("boot_rdy9", 160'(in_rdy), 160'(1));

    waited = 0;
    while (!init_done1 && waited < 20) begin tick(); waited++; end
    chk("dut1_init_done", 160'(init_done1), 160'(1));

    // Back-to-back stream: pushed at edge k, visible after edge k+1
    for (int k = 0; k < NV; k++) begin
      drive(tbl[k].wen, tbl[k].addr, tbl[k].data, tbl[k].thr);
      chk($sformatf("stream_rdy%0d", k), 160'(in_rdy), 160'(1));
      tick();
      if (k > 0) check_vec(k - 1);
    end
    in_vld = 1'b0;
    tick();
    check_vec(NV - 1);
    tick();
    chk("stream_empty_wen", 160'(write0_wen), 160'(0));
    chk("stream_empty_thread_hold", 160'(write_thread), 160'(tbl[NV-1].thr));
    chk("stream_err", 160'(err_addr), 160'(0));

    // Flush: t0 head dies on the pop edge, t1 survives, t0 pushed with flush dies
    a = '0; a[0] = 6'd1; d = '1;
    drive(10'h001, a, d, 1'b0);
    tick();
    a[1] = 6'd2;
    drive(10'h002, a, d, 1'b1); flush = 1'b1; flush_thread = 1'b0;
    tick();
    chk("flush_a_wen", 160'(write0_wen), 160'(0));
    drive(10'h004, a, d, 1'b0);
    tick();
    chk("flush_b_wen", 160'(write0_wen), 160'(10'h002));
    chk("flush_b_thread", 160'(write_thread), 160'(1));
    in_vld = 1'b0; flush = 1'b0;
    tick();
    chk("flush_c_wen", 160'(write0_wen), 160'(0));
    tick();
    chk("flush_drain_wen", 160'(write0_wen), 160'(0));

    // Range: addr 40 is dropped only when ADDR_COUNT=32
    a = '0; a[0] = 6'd40; a[1] = 6'd7;
    drive(10'h003, a, d, 1'b0);
    tick();
    in_vld = 1'b0;
    chk("range_err_before", 160'(err_addr), 160'(0));
    tick();
    chk("range_wen", 160'(write0_wen), 160'(10'h002));
    chk("range_err", 160'(err_addr), 160'(1));
    chk("range_extra1_wen", 160'(write0_wen1), 160'(10'h003));
    chk("range_extra1_err", 160'(err_addr1), 160'(0));
    tick(); tick();
    chk("range_err_sticky", 160'(err_addr), 160'(1));

    // Reset with groups in flight: nothing queued is ever written
    for (int i = 0; i < 10; i++) begin a[i] = 6'(i); d[i] = 16'h5555; end
    drive(10'h3FF, a, d, 1'b1);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("midrst_wen", 160'(write0_wen), 160'(0));
    chk("midrst_err_clr", 160'(err_addr), 160'(0));
    chk("midrst_done", 160'(init_done), 160'(0));
    rst = 1'b0;
    check_init_sweep("rerun");
    in_vld = 1'b0;
    tick();
    chk("rerun_done9", 160'(init_done), 160'(1));
    chk("rerun_wen9", 160'(write0_wen), 160'(0));
    tick();
    chk("rerun_wen10", 160'(write0_wen), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
